multicycle_control_unit: RTL and testbench

Multi-cycle RV32I control FSM. It is the successor to the single-cycle decoder/branch-select block and is driven by a shared instruction/data memory with a ready handshake. It sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, all six B-type branches and jal. It sits between the instruction register and the datapath muxes, register file write enable, PC write enable and memory strobes.

---
 rtl/multicycle_control_unit.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency R/I/sw/jal 4, lw 5, branch 3 cycles; stalls in FETCH/MEMREAD/MEMWRITE while mem_ready is low.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W      = 4,
    parameter int MEM_HANDSHAKE   = 1,
    parameter int ENABLE_BRANCH_U = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  neg,
    input  logic                  ovf,
    input  logic                  carry,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  adr_src,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            state_o,
    output logic                  illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    state_t     state;
    state_t     state_nx;
    logic       ready;
    logic       taken;
    logic       branch_ok;
    logic [3:0] alu_code;
    logic       pc_write_c;
    logic       ir_write_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       reg_write_c;

    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic use_sub,
                                           input logic use_sra);
        logic [3:0] code;
        case (f3)
            3'b000:  code = use_sub ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = use_sra ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    assign ready = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

    // Branch condition comes straight from this cycle's subtract flags.
    always_comb begin
        taken     = 1'b0;
        branch_ok = 1'b0;
        case (funct3)
            3'b000: begin taken = zero;           branch_ok = 1'b1; end
            3'b001: begin taken = !zero;          branch_ok = 1'b1; end
            3'b100: begin taken = neg ^ ovf;      branch_ok = 1'b1; end
            3'b101: begin taken = !(neg ^ ovf);   branch_ok = 1'b1; end
            3'b110: begin taken = !carry;         branch_ok = (ENABLE_BRANCH_U != 0); end
            3'b111: begin taken = carry;          branch_ok = (ENABLE_BRANCH_U != 0); end
            default: begin taken = 1'b0;          branch_ok = 1'b0; end
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_STORE:  imm_src = 3'b001;
            OP_BRANCH: imm_src = 3'b010;
            OP_JAL:    imm_src = 3'b011;
            default:   imm_src = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_code    = ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_nx   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_nx = S_MEMADR;
                    OP_RTYPE:          state_nx = S_EXECR;
                    OP_ITYPE:          state_nx = S_EXECI;
                    OP_BRANCH:         state_nx = branch_ok ? S_BRANCH : S_HALT;
                    OP_JAL:            state_nx = S_JAL;
                    default:           state_nx = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nx  = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                mem_read_c = 1'b1;
                if (ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
                state_nx    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                if (ready) state_nx = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_code  = alu_dec(funct3, funct7b5, funct7b5);
                state_nx  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_code  = alu_dec(funct3, 1'b0, funct7b5);
                state_nx  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_nx    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_code   = ALU_SUB;
                pc_write_c = taken;
                state_nx   = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
                state_nx   = S_ALUWB;
            end
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_HALT;
        endcase
    end

    // Strobes are gated by rst_n so an asserted reset kills them without waiting for a clock.
    assign pc_write  = rst_n & pc_write_c;
    assign ir_write  = rst_n & ir_write_c;
    assign mem_read  = rst_n & mem_read_c;
    assign mem_write = rst_n & mem_write_c;
    assign reg_write = rst_n & reg_write_c;
    assign illegal   = rst_n & (state == S_HALT);
    assign state_o   = state;

    always_comb begin
        alu_control      = '0;
        alu_control[3:0] = alu_code;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized scoreboard bench for multicycle_control_unit: per-cycle expected outputs are queued by
// the driver and popped by an independent negedge monitor.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero, neg, ovf, carry;
    logic       mem_ready;
    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic [3:0] state_o;

    logic       pc_write2, ir_write2, adr_src2, mem_read2, mem_write2, reg_write2, illegal2;
    logic [1:0] result_src2, alu_src_a2, alu_src_b2;
    logic [2:0] imm_src2;
    logic [3:0] alu_control2;
    logic [3:0] state_o2;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .neg(neg), .ovf(ovf), .carry(carry), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .state_o(state_o), .illegal(illegal)
    );

    // No unsigned branches, memory handshake ignored.
    multicycle_control_unit #(.ALU_CTRL_W(4), .MEM_HANDSHAKE(0), .ENABLE_BRANCH_U(0)) dut_nu (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .neg(neg), .ovf(ovf), .carry(carry), .mem_ready(mem_ready),
        .pc_write(pc_write2), .ir_write(ir_write2), .adr_src(adr_src2), .mem_read(mem_read2),
        .mem_write(mem_write2), .reg_write(reg_write2), .result_src(result_src2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .imm_src(imm_src2),
        .alu_control(alu_control2), .state_o(state_o2), .illegal(illegal2)
    );

    typedef struct {
        logic [23:0] vec;
        logic [23:0] care;
    } rec_t;

    rec_t        q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [2:0]  exp_imm;
    logic [3:0]  cur_flags;
    logic [23:0] obs;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    assign obs = {state_o, pc_write, ir_write, mem_read, mem_write, reg_write, illegal,
                  imm_src, adr_src, result_src, alu_src_a, alu_src_b, alu_control};

    always @(negedge clk) begin
        rec_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_total++;
            if ((obs & e.care) === (e.vec & e.care)) n_pass++;
            else $display("FAIL cycle state=%0d: got %h required %h (care %h) at %0t",
                          e.vec[23:20], obs & e.care, e.vec & e.care, e.care, $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        if (o == SW) return 3'd1;
        if (o == BR) return 3'd2;
        if (o == JL) return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic [3:0] alu_exp(input logic [2:0] f3, input logic f7, input logic is_r);
        case (f3)
            3'd0:    return (is_r && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    // strb = {pc_write, ir_write, mem_read, mem_write, reg_write, illegal}
    // c    = which of {adr_src, result_src, alu_src_a, alu_src_b, alu_control} are defined here
    function automatic rec_t mk(input logic [3:0] st, input logic [5:0] strb, input logic adr,
                                input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                input logic [3:0] alu, input logic [4:0] c);
        rec_t r;
        r.vec  = {st, strb, exp_imm, adr, rs, sa, sb, alu};
        r.care = {4'hF, 6'h3F, 3'h7, c[4], {2{c[3]}}, {2{c[2]}}, {2{c[1]}}, {4{c[0]}}};
        return r;
    endfunction

    task automatic issue(input rec_t r, input logic rdy);
        mem_ready = rdy;
        {zero, neg, ovf, carry} = cur_flags;
        q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return $urandom_range(0, 1) == 1;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_strobes", 32'({pc_write, ir_write, mem_read, mem_write, reg_write, illegal}), 32'd0);
        chk("rst_fetch_mux", 32'({adr_src, result_src, alu_src_a, alu_src_b, alu_control}),
            32'({1'b0, 2'b10, 2'b00, 2'b10, 4'd0}));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input int wf, input int wm, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] d;
        logic        tk;
        logic        halt;
        op = o; funct3 = f3; funct7b5 = f7;
        exp_imm = imm_of(o);
        d = {1'b0, a} - {1'b0, b};
        cur_flags = {d[31:0] == 32'd0, d[31], (a[31] != b[31]) && (d[31] != a[31]), !d[32]};
        case (f3)
            3'd0:    tk = (a == b);
            3'd1:    tk = (a != b);
            3'd4:    tk = ($signed(a) < $signed(b));
            3'd5:    tk = ($signed(a) >= $signed(b));
            3'd6:    tk = (a < b);
            default: tk = (a >= b);
        endcase
        halt = 1'b0;
        repeat (wf) issue(mk(4'd0, 6'b001000, 1'b0, 2'b10, 2'b00, 2'b10, 4'd0, 5'b11111), 1'b0);
        issue(mk(4'd0, 6'b111000, 1'b0, 2'b10, 2'b00, 2'b10, 4'd0, 5'b11111), 1'b1);
        issue(mk(4'd1, 6'b000000, 1'b0, 2'b00, 2'b01, 2'b01, 4'd0, 5'b00111), rnd());
        if (o == LW || o == SW)
            issue(mk(4'd2, 6'b000000, 1'b0, 2'b00, 2'b10, 2'b01, 4'd0, 5'b00111), rnd());
        if (o == LW) begin
            repeat (wm) issue(mk(4'd3, 6'b001000, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 5'b10000), 1'b0);
            issue(mk(4'd3, 6'b001000, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 5'b10000), 1'b1);
            issue(mk(4'd4, 6'b000010, 1'b0, 2'b01, 2'b00, 2'b00, 4'd0, 5'b01000), rnd());
        end else if (o == SW) begin
            repeat (wm) issue(mk(4'd5, 6'b000100, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 5'b10000), 1'b0);
            issue(mk(4'd5, 6'b000100, 1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 5'b10000), 1'b1);
        end else if (o == RT || o == IT) begin
            if (o == RT)
                issue(mk(4'd6, 6'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu_exp(f3, f7, 1'b1), 5'b00111), rnd());
            else
                issue(mk(4'd7, 6'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu_exp(f3, f7, 1'b0), 5'b00111), rnd());
            issue(mk(4'd8, 6'b000010, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 5'b01000), rnd());
        end else if (o == BR) begin
            if (f3 == 3'd2 || f3 == 3'd3) halt = 1'b1;
            else issue(mk(4'd9, {tk, 5'b0}, 1'b0, 2'b00, 2'b10, 2'b00, 4'd1, 5'b01111), rnd());
        end else if (o == JL) begin
            issue(mk(4'd10, 6'b100000, 1'b0, 2'b00, 2'b01, 2'b10, 4'd0, 5'b01111), rnd());
            issue(mk(4'd8, 6'b000010, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 5'b01000), rnd());
        end else begin
            halt = 1'b1;
        end
        if (halt) begin
            repeat (20) issue(mk(4'd11, 6'b000001, 1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 5'b00000), rnd());
            do_reset();
        end
    endtask

    task automatic mid_write_reset();
        do_reset();
        op = SW; funct3 = 3'd2; funct7b5 = 1'b0; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; mem_ready = 1'b0; end
        @(negedge clk);
        chk("mw_state", 32'(state_o), 32'd5);
        chk("mw_strobe", 32'(mem_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mw_async_drop", 32'({mem_write, state_o}), 32'd0);
        @(posedge clk);
        #1;
        chk("mw_held_reset", 32'({mem_write, reg_write, state_o}), 32'd0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("mw_refetch", 32'({state_o, mem_read}), 32'h1);
        @(posedge clk);
        #1;
        chk("mw_decode", 32'(state_o), 32'd1);
    endtask

    task automatic nu_test();
        do_reset();
        op = BR; funct3 = 3'd6; funct7b5 = 1'b0; mem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("nu_halt_state", 32'(state_o2), 32'd11);
        chk("main_fetch_stall", 32'({state_o, mem_read}), 32'h1);
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("nu_halt_hold", 32'({illegal2, pc_write2, ir_write2, mem_read2, mem_write2, reg_write2}),
                32'h20);
        end
        do_reset();
        chk("nu_reset_clears", 32'({illegal2, state_o2}), 32'd0);
    endtask

    initial begin
        logic [6:0]  o;
        logic [31:0] a, b;
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; mem_ready = 1'b0;
        {zero, neg, ovf, carry} = 4'b0; cur_flags = 4'b0; exp_imm = 3'd0;
        do_reset();
        instr(RT, 3'd0, 1'b1, 0, 0, 32'd7, 32'd3);
        instr(LW, 3'd2, 1'b0, 0, 2, 32'd0, 32'd0);
        instr(SW, 3'd2, 1'b0, 1, 1, 32'd0, 32'd0);
        instr(BR, 3'd6, 1'b0, 0, 0, 32'd1, 32'd2);
        instr(BR, 3'd5, 1'b0, 0, 0, 32'd1, 32'd2);
        instr(BR, 3'd1, 1'b0, 0, 0, 32'd5, 32'd5);
        instr(JL, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0);
        instr(7'b1111111, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0);
        instr(BR, 3'd2, 1'b0, 0, 0, 32'd0, 32'd0);
        mid_write_reset();
        nu_test();
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0:       o = LW;
                1:       o = SW;
                2, 3:    o = RT;
                4, 8:    o = IT;
                5, 6:    o = BR;
                7:       o = JL;
                default: o = 7'($urandom);
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = 32'($signed($urandom_range(0, 6)) - 3);
                b = 32'($signed($urandom_range(0, 6)) - 3);
            end
            instr(o, 3'($urandom), rnd(), $urandom_range(0, 2), $urandom_range(0, 2), a, b);
        end
        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
